alu_issue_unit: RTL

//  Initiator side of the ALU interface: accepts abstract ALU operation requests over a

---
 rtl/alu_issue_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - ALU request encoder, issue register and in-order response FIFO
module alu_issue_unit #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [5:0]       opcode,
  output logic [5:0]       func_field,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_taken,
  output logic [TAG_W-1:0] rsp_tag
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // Abstract operation codes
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_LW  = 3'd6;

  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_beq;

  logic [5:0]       enc_opcode;
  logic [5:0]       enc_func;
  logic             enc_beq;

  logic [31:0]      mem_result [DEPTH];
  logic             mem_zero   [DEPTH];
  logic             mem_taken  [DEPTH];
  logic [TAG_W-1:0] mem_tag    [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic accept;
  logic push;
  logic pop;

  // Handshake qualifiers; a pop in the same cycle never frees a slot for push
  assign push      = s1_valid && (count < CW'(DEPTH));
  assign req_ready = !s1_valid || push;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;

  // Translate the abstract op into MIPS opcode/function fields
  always_comb begin
    enc_opcode = 6'h00;
    enc_func   = 6'h00;
    enc_beq    = 1'b0;
    case (req_op)
      OP_ADD: enc_func = 6'h20;
      OP_SUB: enc_func = 6'h22;
      OP_AND: enc_func = 6'h24;
      OP_OR:  enc_func = 6'h25;
      OP_NOR: enc_func = 6'h27;
      OP_SLT: enc_func = 6'h2A;
      OP_LW:  enc_opcode = 6'h23;
      default: begin
        enc_opcode = 6'h04;
        enc_beq    = 1'b1;
      end
    endcase
  end

  // Issue register: ALU-side fields only change on accept so the ALU never sees a glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      opcode     <= 6'h00;
      func_field <= 6'h00;
      alu_a      <= 32'h0;
      alu_b      <= 32'h0;
      s1_tag     <= '0;
      s1_beq     <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        opcode     <= enc_opcode;
        func_field <= enc_func;
        alu_a      <= req_a;
        alu_b      <= req_b;
        s1_tag     <= req_tag;
        s1_beq     <= enc_beq;
      end else if (push) begin
        s1_valid   <= 1'b0;
      end
    end
  end

  // Response FIFO: captures the combinational ALU result while stage 1 holds the op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_result[i] <= 32'h0;
        mem_zero[i]   <= 1'b0;
        mem_taken[i]  <= 1'b0;
        mem_tag[i]    <= '0;
      end
    end else begin
      if (push) begin
        mem_result[wr_ptr] <= alu_result;
        mem_zero[wr_ptr]   <= alu_zero;
        mem_taken[wr_ptr]  <= s1_beq & alu_zero;
        mem_tag[wr_ptr]    <= s1_tag;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rsp_result = mem_result[rd_ptr];
  assign rsp_zero   = mem_zero[rd_ptr];
  assign rsp_taken  = mem_taken[rd_ptr];
  assign rsp_tag    = mem_tag[rd_ptr];

endmodule
